// File: rtl/lut_batch_sequencer_pkg.sv
// Shared types for the LUT batch sequencer: complex sample structs, FSM states
// and the accumulator width rule.
package lut_batch_sequencer_pkg;

  localparam int unsigned DefLutW = 24;
  localparam int unsigned DefNGrp = 4;

  // One extra bit beyond the exact growth keeps the signed sum clear of wrap.
  function automatic int unsigned acc_width(input int unsigned lut_w,
                                            input int unsigned n_grp);
    return lut_w + $clog2(n_grp) + 1;
  endfunction

  localparam int unsigned DefAccW = acc_width(DefLutW, DefNGrp);

  typedef struct packed {
    logic signed [DefLutW-1:0] r;
    logic signed [DefLutW-1:0] i;
  } lut_complex_t;

  typedef struct packed {
    logic signed [DefAccW-1:0] r;
    logic signed [DefAccW-1:0] i;
  } acc_complex_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_e;

endpackage

// File: rtl/lut_batch_sequencer_complex_acc.sv
// Signed complex accumulator with synchronous clear and enable; each input
// component is sign-extended to the accumulator width before the add.
module complex_acc #(
  parameter int unsigned InW  = 24,
  parameter int unsigned OutW = 27
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [2*InW-1:0]  val_i,
  output logic [2*OutW-1:0] acc_o
);

  typedef struct packed {
    logic signed [InW-1:0] r;
    logic signed [InW-1:0] i;
  } in_t;

  typedef struct packed {
    logic signed [OutW-1:0] r;
    logic signed [OutW-1:0] i;
  } out_t;

  in_t  val_s;
  out_t acc_q, acc_d;
  logic signed [OutW-1:0] ext_r, ext_i;

  assign val_s = val_i;
  assign ext_r = {{(OutW-InW){val_s.r[InW-1]}}, val_s.r};
  assign ext_i = {{(OutW-InW){val_s.i[InW-1]}}, val_s.i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d.r = acc_q.r + ext_r;
      acc_d.i = acc_q.i + ext_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/lut_batch_sequencer.sv
// Walks a wide control-bit word through one shared coefficient LUT, one group
// per cycle, and hands the accumulated complex total downstream.
module lut_batch_sequencer
  import lut_batch_sequencer_pkg::*;
#(
  parameter int unsigned LUT_SIZE = 4,
  parameter int unsigned N_GRP    = 4,
  parameter int unsigned LUT_W    = 24,
  localparam int unsigned ACC_W   = acc_width(LUT_W, N_GRP)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_GRP*LUT_SIZE-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LUT_SIZE-1:0]       lut_sel,
  input  logic [2*LUT_W-1:0]        lut_result,
  output logic [2*ACC_W-1:0]        out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned WordW = N_GRP * LUT_SIZE;
  localparam int unsigned CntW  = (N_GRP > 1) ? $clog2(N_GRP) : 1;

  seq_state_e        state_q, state_d;
  logic [WordW-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept;
  logic              last_grp;
  logic              acc_clear;
  logic              acc_en;

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;
  assign last_grp = (cnt_q == CntW'(N_GRP - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d   = in_data;
          cnt_d     = '0;
          acc_clear = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        acc_en  = 1'b1;
        shift_d = shift_q >> LUT_SIZE;
        cnt_d   = cnt_q + CntW'(1);
        if (last_grp) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Taking the result and the next word on one edge avoids an idle bubble.
        if (accept) begin
          shift_d   = in_data;
          cnt_d     = '0;
          acc_clear = 1'b1;
          state_d   = StRun;
        end else if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  complex_acc #(
    .InW  (LUT_W),
    .OutW (ACC_W)
  ) u_acc (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (acc_clear),
    .en_i    (acc_en),
    .val_i   (lut_result),
    .acc_o   (out_data)
  );

  assign lut_sel   = (state_q == StRun) ? shift_q[LUT_SIZE-1:0] : '0;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_lut_batch_sequencer.sv
// Directed and randomised checks of lut_batch_sequencer against a small LUT
// model and an in-order scoreboard of expected sums.
module tb_lut_batch_sequencer;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  in_data;
  logic        in_valid, in_ready;
  logic [1:0]  lut_sel;
  logic [15:0] lut_result;
  logic [19:0] out_data;
  logic        out_valid, out_ready, busy;

  logic [1:0]  in_data1;
  logic        in_valid1, in_ready1;
  logic [1:0]  lut_sel1;
  logic [15:0] lut_result1;
  logic [17:0] out_data1;
  logic        out_valid1, out_ready1, busy1;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int dropped = 0;
  int received = 0;
  logic [19:0] sb[$];
  logic        stall_q = 1'b0;
  logic [19:0] held_q;

  always #5 clk = ~clk;

  function automatic int lut_re(input logic [1:0] s);
    return (s[0] ? 3 : -3) + (s[1] ? 5 : -5);
  endfunction

  function automatic int lut_im(input logic [1:0] s);
    return (s[0] ? 1 : -1) + (s[1] ? -2 : 2);
  endfunction

  function automatic logic [19:0] pack10(input int r, input int i);
    return {10'(r), 10'(i)};
  endfunction

  function automatic logic [19:0] model_sum(input logic [3:0] w);
    return pack10(lut_re(w[1:0]) + lut_re(w[3:2]), lut_im(w[1:0]) + lut_im(w[3:2]));
  endfunction

  assign lut_result  = {8'(lut_re(lut_sel)), 8'(lut_im(lut_sel))};
  assign lut_result1 = {8'(lut_re(lut_sel1)), 8'(lut_im(lut_sel1))};

  lut_batch_sequencer #(
    .LUT_SIZE (2),
    .N_GRP    (2),
    .LUT_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lut_sel    (lut_sel),
    .lut_result (lut_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  lut_batch_sequencer #(
    .LUT_SIZE (2),
    .N_GRP    (1),
    .LUT_W    (8)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .lut_sel    (lut_sel1),
    .lut_result (lut_result1),
    .out_data   (out_data1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .busy       (busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples on the falling edge, between input updates.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      dropped += sb.size();
      sb.delete();
      stall_q = 1'b0;
    end else if (rst === 1'b0) begin
      if (out_valid && stall_q) check("hold_stable", 32'(out_data), 32'(held_q));
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected_output: observed=%0h expected=none", out_data);
        end
        if (sb.size() != 0) begin
          check("sb_out_data", 32'(out_data), 32'(sb.pop_front()));
          received++;
        end
      end
      stall_q = out_valid && !out_ready;
      held_q  = out_data;
      if (in_valid && in_ready) begin
        sb.push_back(model_sum(in_data));
        pushed++;
      end
    end
  end

  initial begin
    int  sent;
    int  guard;
    logic acc_now;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; in_data1 = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lut_sel", 32'(lut_sel), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Single word 0111: groups 11 then 01.
    in_data = 4'b0111; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_sel_g0", 32'(lut_sel), 32'b11);
    tick();
    check("t1_sel_g1", 32'(lut_sel), 32'b01);
    check("t1_not_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'(pack10(6, 2)));
    check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    check("t1_idle_ready", 32'(in_ready), 32'd1);

    // Back-to-back 1111 then 0011.
    in_data = 4'b1111; in_valid = 1'b1;
    tick();
    in_data = 4'b0011;
    tick();
    tick();
    check("t2_first_valid", 32'(out_valid), 32'd1);
    check("t2_first_data", 32'(out_data), 32'(pack10(16, -2)));
    check("t2_ready_in_done", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t2_direct_run", 32'(busy), 32'd1);
    check("t2_sel_g0", 32'(lut_sel), 32'b11);
    tick();
    tick();
    check("t2_second_data", 32'(out_data), 32'(pack10(0, 0)));
    tick();
    check("t2_idle", 32'(out_valid), 32'd0);

    // Output stall with competing input held off.
    in_data = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_data = 4'b1010;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_data", 32'(out_data), 32'(pack10(-16, 2)));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t3_release_valid", 32'(out_valid), 32'd1);
    tick();
    check("t3_idle_valid", 32'(out_valid), 32'd0);
    check("t3_idle_ready", 32'(in_ready), 32'd1);
    check("t3_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of RUN.
    in_data = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_ready", 32'(in_ready), 32'd1);
    check("t4_sel", 32'(lut_sel), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    in_data = 4'b1001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t4_valid_after", 32'(out_valid), 32'd1);
    check("t4_data", 32'(out_data), 32'(pack10(0, 0)));
    tick();

    // Random words with stalls on both sides.
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = 4'($urandom);
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      tick();
      guard++;
      if (acc_now) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("rand_sent", 32'(sent), 32'd1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    check("rand_drained", 32'(sb.size()), 32'd0);
    check("rand_count", 32'(received), 32'(pushed - dropped));
    check("rand_idle", 32'(out_valid), 32'd0);

    // Single-group build.
    in_data1 = 2'b10; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("g1_busy", 32'(busy1), 32'd1);
    check("g1_sel", 32'(lut_sel1), 32'b10);
    check("g1_not_valid", 32'(out_valid1), 32'd0);
    tick();
    check("g1_valid", 32'(out_valid1), 32'd1);
    check("g1_data", 32'(out_data1), 32'({9'(2), 9'(-3)}));
    tick();
    check("g1_idle", 32'(out_valid1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
